// File: rtl/pipelined_adder.sv
// Pipelined ripple-segment adder/subtractor: a WIDTH-bit add is split into
// WIDTH/SEG segments, one per clock, with the segment carry registered between stages.
module pipelined_adder #(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   input  logic             sub,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf
);

   localparam int STAGES = WIDTH / SEG;

   if (SEG < 1 || WIDTH < SEG || (WIDTH % SEG) != 0) begin : g_bad_params
      $error("pipelined_adder: WIDTH (%0d) must be a non-zero multiple of SEG (%0d)", WIDTH, SEG);
   end

   // Handshake: a beat moves on a side when valid & ready are both 1 at the rising edge.
   // The whole pipe, outputs included, freezes while a result waits on out_ready.
   logic stall;
   assign stall    = out_valid & ~out_ready;
   assign in_ready = ~stall;

   // Level k holds operands (b already conditioned), the carry into segment k,
   // and the result segments below k.
   logic             valid_q [STAGES];
   logic [WIDTH-1:0] a_q     [STAGES];
   logic [WIDTH-1:0] b_q     [STAGES];
   logic [WIDTH-1:0] psum_q  [STAGES];
   logic             c_q     [STAGES];

   logic [SEG:0]     seg_res  [STAGES];
   logic [WIDTH-1:0] psum_nxt [STAGES];

   function automatic logic [WIDTH-1:0] put_seg(input logic [WIDTH-1:0] v, input int k,
                                                input logic [SEG-1:0] s);
      logic [WIDTH-1:0] r;
      r = v;
      r[k*SEG +: SEG] = s;
      return r;
   endfunction

   for (genvar k = 0; k < STAGES; k++) begin : g_seg
      assign seg_res[k]  = {1'b0, a_q[k][k*SEG +: SEG]} + {1'b0, b_q[k][k*SEG +: SEG]}
                         + {{SEG{1'b0}}, c_q[k]};
      assign psum_nxt[k] = put_seg(psum_q[k], k, seg_res[k][SEG-1:0]);
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int k = 0; k < STAGES; k++) begin
            valid_q[k] <= 1'b0;
            a_q[k]     <= '0;
            b_q[k]     <= '0;
            psum_q[k]  <= '0;
            c_q[k]     <= 1'b0;
         end
         out_valid <= 1'b0;
         sum       <= '0;
         cout      <= 1'b0;
         ovf       <= 1'b0;
      end else if (!stall) begin
         valid_q[0] <= in_valid;
         if (in_valid) begin
            a_q[0]    <= a;
            b_q[0]    <= sub ? ~b : b;
            c_q[0]    <= sub ? ~cin : cin;
            psum_q[0] <= '0;
         end
         // Data only advances with a valid beat so bubbles keep the last values.
         for (int k = 0; k < STAGES - 1; k++) begin
            valid_q[k+1] <= valid_q[k];
            if (valid_q[k]) begin
               a_q[k+1]    <= a_q[k];
               b_q[k+1]    <= b_q[k];
               c_q[k+1]    <= seg_res[k][SEG];
               psum_q[k+1] <= psum_nxt[k];
            end
         end
         out_valid <= valid_q[STAGES-1];
         if (valid_q[STAGES-1]) begin
            sum  <= psum_nxt[STAGES-1];
            cout <= seg_res[STAGES-1][SEG];
            ovf  <= (a_q[STAGES-1][WIDTH-1] == b_q[STAGES-1][WIDTH-1]) &&
                    (seg_res[STAGES-1][SEG-1] != a_q[STAGES-1][WIDTH-1]);
         end
      end
   end

endmodule

// File: tb/tb_pipelined_adder.sv
// Bench for pipelined_adder: directed vectors, streaming, backpressure and reset flush
// on a 16/4 instance, plus a single-stage 8/8 instance.
module tb_pipelined_adder;

   logic        clk;
   logic        reset;
   logic        in_valid, in_ready, cin, sub, out_valid, out_ready, cout, ovf;
   logic [15:0] a, b, sum;
   logic        in_valid8, in_ready8, cin8, sub8, out_valid8, out_ready8, cout8, ovf8;
   logic [7:0]  a8, b8, sum8;

   int          n_cmp = 0;
   int          n_bad = 0;
   int          n_out = 0;
   int          cyc = 0;
   int          stall_cnt = 0;
   logic        prev_stall = 1'b0;
   logic [15:0] prev_sum;
   logic        prev_cout, prev_ovf;
   logic [17:0] exp_q[$];

   pipelined_adder #(.WIDTH(16), .SEG(4)) dut (
      .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
      .a(a), .b(b), .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready),
      .sum(sum), .cout(cout), .ovf(ovf)
   );

   pipelined_adder #(.WIDTH(8), .SEG(8)) dut8 (
      .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .cin(cin8), .sub(sub8), .out_valid(out_valid8), .out_ready(out_ready8),
      .sum(sum8), .cout(cout8), .ovf(ovf8)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: plain integer arithmetic, {cout, ovf, sum}.
   function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                         input logic mc, input logic ms);
      int ua, ub, sa, sb, ci, sr;
      logic co;
      logic [15:0] s;
      ua = int'(ma);
      ub = int'(mb);
      sa = int'($signed(ma));
      sb = int'($signed(mb));
      ci = mc ? 1 : 0;
      if (ms) begin
         s  = 16'(ua - ub - ci);
         co = (ua >= ub + ci);
         sr = sa - sb - ci;
      end else begin
         s  = 16'(ua + ub + ci);
         co = (ua + ub + ci) > 65535;
         sr = sa + sb + ci;
      end
      return {co, (sr > 32767 || sr < -32768), s};
   endfunction

   // scoreboard / monitor, sampled on the falling edge
   always @(negedge clk) begin
      logic [17:0] e;
      if (reset) begin
         exp_q.delete();
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            check("hold_valid", out_valid, 1);
            check("hold_sum", sum, prev_sum);
            check("hold_flags", {cout, ovf}, {prev_cout, prev_ovf});
         end
         if (out_valid && !out_ready) begin
            stall_cnt++;
            check("stall_in_ready", in_ready, 0);
         end
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("unexpected_out", out_valid, 0);
            end else begin
               e = exp_q.pop_front();
               check("out_sum", sum, e[15:0]);
               check("out_cout", cout, e[17]);
               check("out_ovf", ovf, e[16]);
               n_out++;
            end
         end
         if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, sub));
         prev_stall = out_valid & ~out_ready;
         prev_sum   = sum;
         prev_cout  = cout;
         prev_ovf   = ovf;
      end
   end

   // driver tasks
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic send_beat(input logic [15:0] xa, input logic [15:0] xb,
                            input logic xc, input logic xs);
      logic got;
      bit   done;
      done = 0;
      in_valid = 1'b1;
      a = xa; b = xb; cin = xc; sub = xs;
      for (int t = 0; t < 50 && !done; t++) begin
         @(negedge clk);
         got = in_ready;
         tick();
         if (got) done = 1;
      end
      if (!done) check("accept_timeout", 0, 1);
   endtask

   task automatic drain();
      for (int t = 0; t < 40 && exp_q.size() != 0; t++) tick();
      check("drain", exp_q.size(), 0);
   endtask

   task automatic run_directed(input string tag, input logic [15:0] xa, input logic [15:0] xb,
                               input logic xc, input logic xs, input logic [15:0] es,
                               input logic ec, input logic eo);
      send_beat(xa, xb, xc, xs);
      in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check({tag, "_early"}, out_valid, 0);
         tick();
      end
      check({tag, "_early"}, out_valid, 0);
      tick();
      check({tag, "_valid"}, out_valid, 1);
      check({tag, "_sum"}, sum, es);
      check({tag, "_cout"}, cout, ec);
      check({tag, "_ovf"}, ovf, eo);
      tick();
   endtask

   initial begin
      int   base, c0;
      logic seen;
      reset = 1'b1;
      in_valid = 1'b1; a = 16'h1234; b = 16'h4321; cin = 1'b1; sub = 1'b0;
      out_ready = 1'b1;
      in_valid8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0; sub8 = 1'b0; out_ready8 = 1'b1;

      // reset held 3 cycles with in_valid high
      repeat (3) tick();
      check("rst_out_valid", out_valid, 0);
      check("rst_sum", sum, 16'h0000);
      check("rst_cout", cout, 0);
      check("rst_ovf", ovf, 0);
      check("rst_out_valid8", out_valid8, 0);
      reset = 1'b0;
      in_valid = 1'b0;
      check("rst_in_ready", in_ready, 1);
      tick();
      check("rst_in_ready_after", in_ready, 1);
      check("rst_idle", out_valid, 0);

      // directed vectors, hand-computed
      run_directed("carry_ripple", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
      run_directed("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
      run_directed("sub_borrow", 16'h0003, 16'h0005, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
      run_directed("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
      run_directed("add_cin", 16'h1234, 16'h0FFF, 1'b1, 1'b0, 16'h2234, 1'b0, 1'b0);
      run_directed("sub_cin", 16'h0005, 16'h0003, 1'b1, 1'b1, 16'h0001, 1'b1, 1'b0);
      run_directed("sub_all_ones", 16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF, 1'b0, 1'b0);

      // back-to-back streaming
      base = n_out;
      c0 = cyc;
      for (int i = 0; i < 32; i++)
         send_beat(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      check("stream_rate", cyc - c0, 32);
      in_valid = 1'b0;
      drain();
      check("stream_count", n_out - base, 32);

      // backpressure mid-stream
      base = n_out;
      stall_cnt = 0;
      fork
         begin
            for (int i = 0; i < 8; i++)
               send_beat(16'($urandom_range(0, 65535)), 16'($urandom_range(0, 65535)),
                         1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            in_valid = 1'b0;
         end
         begin
            repeat (6) @(posedge clk);
            #1 out_ready = 1'b0;
            repeat (5) @(posedge clk);
            #1 out_ready = 1'b1;
         end
      join
      drain();
      check("bp_count", n_out - base, 8);
      check("bp_stall_cycles", stall_cnt, 5);

      // reset mid-flight
      for (int i = 0; i < 3; i++) send_beat(16'h1000 + 16'(i), 16'h0101, 1'b0, 1'b0);
      in_valid = 1'b0;
      reset = 1'b1;
      tick();
      reset = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 8; i++) begin
         seen = seen | out_valid;
         tick();
      end
      check("flush_no_out", seen, 0);
      check("flush_queue", exp_q.size(), 0);

      // single-stage instance: latency 1
      in_valid8 = 1'b1; a8 = 8'h7F; b8 = 8'h01; cin8 = 1'b0; sub8 = 1'b0;
      check("w8_in_ready", in_ready8, 1);
      tick();
      in_valid8 = 1'b0;
      check("w8_early", out_valid8, 0);
      tick();
      check("w8_valid", out_valid8, 1);
      check("w8_sum", sum8, 8'h80);
      check("w8_ovf", ovf8, 1);
      check("w8_cout", cout8, 0);
      tick();
      check("w8_done", out_valid8, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
